// File: rtl/req_pkg.sv
// Shared constants, request-vector type and index decode for the request latch.
// Pure declarations; no clocked logic and no flow control.
// The line count is fixed to the width of the downstream 4-to-2 priority encoder.
package req_pkg;

  localparam int N_REQ           = 4;
  localparam int IDX_W           = 2;
  localparam int SYNC_STAGES_DEF = 2;

  typedef logic [N_REQ-1:0] req_vec_t;

  // One-hot mask selecting the line named by an encoder index.
  function automatic req_vec_t idx_onehot(input logic [IDX_W-1:0] idx);
    return req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/request_latch_if.sv
// Request/ack bundle between request_latch and its consumer (encoder plus ack logic).
// Wiring only: no latency.
// Acknowledges are one-cycle strobes, so there is no backpressure.
interface request_latch_if;
  import req_pkg::*;

  req_vec_t               req_in;
  logic                   ack;
  logic [IDX_W-1:0]       ack_idx;
  logic                   ovf_clr;
  req_vec_t               pend;
  logic                   any_pend;
  req_vec_t               ovf;

  modport master (
    output req_in, ack, ack_idx, ovf_clr,
    input  pend, any_pend, ovf
  );

  modport slave (
    input  req_in, ack, ack_idx, ovf_clr,
    output pend, any_pend, ovf
  );

endinterface

// File: rtl/request_latch_sync_edge.sv
// Synchronizes one asynchronous request line and flags its rising edges.
// ev is asserted STAGES-1 cycles after the edge that first samples d high.
// No backpressure: a level that stays high yields a single event.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic ev
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      hist_q <= sync_q[STAGES-1];
    end
  end

  // Clearing hist_q on reset makes a line held high through reset report once.
  assign ev = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/request_latch.sv
// Holds sticky pending bits for four async request lines until acked by index.
// pend sets SYNC_STAGES cycles after a rising edge is sampled; an ack clears it the next cycle.
// No backpressure: an event on an already-pending line is dropped and flagged in ovf.
module request_latch
  import req_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  request_latch_if.slave  bus
);

  req_vec_t ev;
  req_vec_t hit;
  req_vec_t ovf_set;
  req_vec_t pend_q;
  req_vec_t ovf_q;

  for (genvar i = 0; i < N_REQ; i++) begin : g_line
    sync_edge #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.req_in[i]),
      .ev  (ev[i])
    );
  end

  always_comb begin
    hit     = '0;
    if (bus.ack) begin
      hit = idx_onehot(bus.ack_idx);
    end
    // An event landing together with its own ack re-arms the bit, so no loss.
    ovf_set = ev & pend_q & ~hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      pend_q <= ev | (pend_q & ~hit);
      ovf_q  <= ovf_set | (bus.ovf_clr ? '0 : ovf_q);
    end
  end

  assign bus.pend     = pend_q;
  assign bus.any_pend = |pend_q;
  assign bus.ovf      = ovf_q;

  a_ack_idx_known: assert property (@(posedge clk) disable iff (rst)
    bus.ack |-> !$isunknown(bus.ack_idx));

endmodule

// File: tb/tb_request_latch.sv
// Directed and randomized checks of request_latch against an event-schedule model.
module tb_request_latch;

  localparam int SYNC = 2;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  request_latch_if bus ();

  request_latch #(
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each sampled rising edge is scheduled to land SYNC edges later.
  logic [3:0] m_pend = '0;
  logic [3:0] m_ovf  = '0;
  logic [3:0] m_prev = '0;
  logic [3:0] sched [int];
  int         cnt    = 0;

  always @(posedge clk) begin
    logic [3:0] ev_now, hit_now, rise;
    if (rst) begin
      m_pend = '0;
      m_ovf  = '0;
      m_prev = '0;
      sched.delete();
    end else begin
      ev_now = sched.exists(cnt) ? sched[cnt] : 4'b0000;
      sched.delete(cnt);
      hit_now = bus.ack ? (4'b0001 << bus.ack_idx) : 4'b0000;
      m_ovf  = (ev_now & m_pend & ~hit_now) | (bus.ovf_clr ? 4'b0000 : m_ovf);
      m_pend = ev_now | (m_pend & ~hit_now);
      rise   = bus.req_in & ~m_prev;
      m_prev = bus.req_in;
      if (rise != 4'b0000) sched[cnt + SYNC] = rise;
    end
    cnt++;
  end

  function automatic logic [1:0] enc_y(input logic [3:0] a);
    for (int i = 3; i >= 0; i--) begin
      if (a[i]) return 2'(i);
    end
    return 2'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    bus.ack     = 1'b0;
    bus.ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst = 1'b1; bus.req_in = 4'b0000;
    repeat (3) begin
      tick();
      checks++;
      if (bus.pend !== 4'b0000 || bus.ovf !== 4'b0000 || bus.any_pend !== 1'b0) begin
        failures++;
        $display("FAIL reset_clear pend=%b ovf=%b any_pend=%b required 0000 0000 0",
                 bus.pend, bus.ovf, bus.any_pend);
      end
    end
    bus.req_in = 4'b0100;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp = (c >= 3) ? 4'b0100 : 4'b0000;
      checks++;
      if (bus.pend !== exp) begin
        failures++;
        $display("FAIL reset_release_high c=%0d pend=%b required %b", c, bus.pend, exp);
      end
    end
    checks++;
    if (bus.ovf !== 4'b0000) begin
      failures++;
      $display("FAIL reset_release_once ovf=%b required 0000", bus.ovf);
    end
    bus.req_in = 4'b0000; bus.ack = 1'b1; bus.ack_idx = 2'd2;
    tick();
    checks++;
    if (bus.pend !== 4'b0000) begin
      failures++;
      $display("FAIL reset_release_ack pend=%b required 0000", bus.pend);
    end
    tick();
  endtask

  task automatic test_latency_priority();
    bus.req_in = 4'b1010;
    for (int c = 0; c <= 2; c++) begin
      tick();
      checks++;
      if (bus.pend !== ((c == 2) ? 4'b1010 : 4'b0000)) begin
        failures++;
        $display("FAIL latency c=%0d pend=%b required %b", c, bus.pend,
                 (c == 2) ? 4'b1010 : 4'b0000);
      end
    end
    bus.ack = 1'b1; bus.ack_idx = enc_y(bus.pend);
    tick();
    checks++;
    if (bus.pend !== 4'b0010 || enc_y(bus.pend) !== 2'd1) begin
      failures++;
      $display("FAIL ack_top pend=%b y=%0d required 0010 y=1", bus.pend, enc_y(bus.pend));
    end
    bus.ack = 1'b1; bus.ack_idx = enc_y(bus.pend);
    tick();
    checks++;
    if (bus.pend !== 4'b0000 || bus.any_pend !== 1'b0) begin
      failures++;
      $display("FAIL ack_last pend=%b any_pend=%b required 0000 0", bus.pend, bus.any_pend);
    end
    bus.req_in = 4'b0000;
    repeat (2) tick();
  endtask

  task automatic test_overflow();
    bus.req_in = 4'b0001; tick();
    bus.req_in = 4'b0000; tick();
    bus.req_in = 4'b0001; tick();
    bus.req_in = 4'b0000;
    repeat (4) tick();
    checks++;
    if (bus.pend !== 4'b0001 || bus.ovf !== 4'b0001) begin
      failures++;
      $display("FAIL overflow_set pend=%b ovf=%b required 0001 0001", bus.pend, bus.ovf);
    end
    bus.ovf_clr = 1'b1;
    tick();
    checks++;
    if (bus.ovf !== 4'b0000 || bus.pend !== 4'b0001) begin
      failures++;
      $display("FAIL overflow_clr pend=%b ovf=%b required 0001 0000", bus.pend, bus.ovf);
    end
    bus.ack = 1'b1; bus.ack_idx = 2'd0;
    tick();
  endtask

  task automatic test_collision();
    bus.req_in = 4'b0100; tick();
    bus.req_in = 4'b0000;
    repeat (4) tick();
    bus.req_in = 4'b0100;
    tick();
    tick();
    bus.ack = 1'b1; bus.ack_idx = 2'd2;
    tick();
    checks++;
    if (bus.pend[2] !== 1'b1 || bus.ovf[2] !== 1'b0) begin
      failures++;
      $display("FAIL collision pend2=%b ovf2=%b required 1 0", bus.pend[2], bus.ovf[2]);
    end
    bus.req_in = 4'b0000; bus.ack = 1'b1; bus.ack_idx = 2'd2;
    tick();
    tick();
  endtask

  task automatic test_spurious_level();
    bus.req_in = 4'b0100; tick();
    bus.req_in = 4'b0000;
    repeat (4) tick();
    bus.ack = 1'b1; bus.ack_idx = 2'd1;
    tick();
    checks++;
    if (bus.pend !== 4'b0100) begin
      failures++;
      $display("FAIL spurious_ack pend=%b required 0100", bus.pend);
    end
    bus.req_in = 4'b0010;
    for (int c = 1; c <= 20; c++) begin
      if (c == 5) begin
        bus.ack = 1'b1; bus.ack_idx = 2'd1;
      end
      tick();
      if (c == 3) begin
        checks++;
        if (bus.pend !== 4'b0110) begin
          failures++;
          $display("FAIL level_set pend=%b required 0110", bus.pend);
        end
      end
      if (c >= 5) begin
        checks++;
        if (bus.pend !== 4'b0100) begin
          failures++;
          $display("FAIL level_hold c=%0d pend=%b required 0100", c, bus.pend);
        end
      end
    end
    bus.req_in = 4'b0000; bus.ack = 1'b1; bus.ack_idx = 2'd2;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.req_in = 4'b1111; tick();
    bus.req_in = 4'b0000; tick();
    bus.req_in = 4'b0011; tick();
    bus.req_in = 4'b0000;
    repeat (4) tick();
    checks++;
    if (bus.pend !== 4'b1111 || bus.ovf !== 4'b0011) begin
      failures++;
      $display("FAIL mid_setup pend=%b ovf=%b required 1111 0011", bus.pend, bus.ovf);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.pend !== 4'b0000 || bus.ovf !== 4'b0000 || bus.any_pend !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset c=%0d pend=%b ovf=%b any_pend=%b required 0000 0000 0",
                 c, bus.pend, bus.ovf, bus.any_pend);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      bus.req_in  = bus.req_in ^ (4'($urandom) & 4'($urandom));
      bus.ack     = ($urandom_range(0, 2) != 0);
      bus.ack_idx = ($urandom_range(0, 1) == 0) ? enc_y(bus.pend) : 2'($urandom_range(0, 3));
      bus.ovf_clr = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (bus.pend !== m_pend || bus.ovf !== m_ovf || bus.any_pend !== (|m_pend)) begin
        failures++;
        $display("FAIL random c=%0d pend=%b ovf=%b any_pend=%b required %b %b %b",
                 c, bus.pend, bus.ovf, bus.any_pend, m_pend, m_ovf, |m_pend);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    bus.req_in  = 4'b0000;
    bus.ack     = 1'b0;
    bus.ack_idx = 2'd0;
    bus.ovf_clr = 1'b0;
    test_reset();
    test_latency_priority();
    test_overflow();
    test_collision();
    test_spurious_level();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/request_latch.md
# request_latch

Captures four asynchronous request lines and holds them as sticky pending bits until acknowledged. Its `pend[3:0]` output drives the 4-to-2 priority encoder's `a` input directly. The encoder's `y` output and a consumer-generated `ack` strobe return to this block to clear the serviced request. Per-line overflow flags record events lost because the line was already pending.

## Interface
- `N_REQ`, 4, number of request lines; fixed to match the encoder width
- `SYNC_STAGES`, 2, synchronizer flops per line; legal values 2..3
- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: reset is synchronous and active-high
- `req_in` in 4: raw asynchronous request lines, active-high, level
- `ack` in 1: one-cycle strobe, "request `ack_idx` serviced"
- `ack_idx` in 2: index of serviced line; connected to the encoder `y`
- `ovf_clr` in 1: one-cycle strobe clearing all overflow flags
- `pend` out 4: sticky pending requests; feeds encoder `a`
- `any_pend` out 1: OR of `pend`
- `ovf` out 4: sticky per-line overflow flags

## Operation
- Per line i, the datapath is:
  - `SYNC_STAGES`-flop synchronizer, producing `s[i]`.
  - One history flop, producing `h[i]`.
  - Event detect: `ev[i] = s[i] & ~h[i]`, a rising edge only.
  - Level-high lines generate no further events.
- Pending update, per bit, priority high to low:
  1. If `rst`, clear to 0.
  2. If `ev[i]`, set to 1.
  3. If `ack && ack_idx==i`, clear to 0.
  4. Otherwise hold.
- Simultaneous `ev[i]` and ack of bit i:
  - The set wins, so the new event is not lost.
  - This is not counted as an overflow.
- Overflow, per bit:
  - `ovf[i]` sets when `ev[i]` occurs while `pend[i]==1` and the same cycle carries no ack of bit i.
  - It clears on `ovf_clr` or `rst`.
  - If a set and `ovf_clr` coincide, the set wins.
- Acknowledgement rules:
  - `ack` of a bit that is already 0 is ignored; no error.
  - `ack_idx` is don't-care when `ack==0`.
- `any_pend` is combinational OR of the `pend` register only.
  - No input reaches it combinationally, so it is glitch-free.
- Reset values:
  - All synchronizer flops, `h`, `pend` and `ovf` are 0.
  - Consequently `any_pend` is 0 during and after reset.
- Line high at reset release:
  - Produces exactly one event.
  - This is the intended power-up behaviour; a stuck-high line is reported once.
- Reset asserted mid-operation:
  - Discards all pending and overflow state.
  - Events in flight in the synchronizer are lost.

## Timing
- Event latency:
  - `req_in[i]` first sampled high at edge k.
  - `pend[i]` reads 1 after edge k+`SYNC_STAGES`.
  - With the default, that is 2 cycles.
- Ack latency:
  - `ack` asserted in the cycle before edge m.
  - `pend[i]` reads 0 after edge m.
  - The encoder output updates combinationally in the same cycle.
- Pulse width:
  - Minimum detectable `req_in` pulse is one full clock period, high across one rising edge.
  - Narrower pulses may be missed.
- Re-arm: the line must be low for at least one sampled edge before a new rising edge counts.
- Throughput: one ack per cycle; back-to-back acks on different indices are legal.

## Structure
- Shared package `req_pkg`:
  - `N_REQ = 4`
  - `IDX_W = 2`
  - `SYNC_STAGES_DEF = 2`
  - A typedef for the 4-bit request vector.
- Sub-module `sync_edge` handles one line:
  - Synchronizer chain, history flop and `ev` output.
  - It is instantiated `N_REQ` times.
- Pending and overflow registers and the ack decode live in `request_latch`.
- Top-level pairing: `request_latch.pend` → `priority_encoder.a`; `priority_encoder.y` → `request_latch.ack_idx`.

## Test plan
- **Reset:**
  - Stimulus: `rst`=1 for 3 cycles with `req_in`=4'b0000.
  - Required: `pend`=0, `ovf`=0, `any_pend`=0.
  - Then with `req_in`=4'b0100 held through reset release: `pend`=4'b0100 exactly 2 cycles after release, set once only.
- **Latency and priority:**
  - Stimulus: `req_in` rises 4'b0000→4'b1010 before edge k.
  - Required: `pend`=4'b1010 after edge k+2, so the encoder gives `y`=3.
  - Stimulus: `ack` with `ack_idx`=3.
  - Required: `pend`=4'b0010 next cycle, encoder `y`=1.
  - Stimulus: ack 1.
  - Required: `pend`=0, `any_pend`=0.
- **Overflow:**
  - Stimulus: line 0 pulses high-low-high with no ack.
  - Required: `pend[0]`=1 and `ovf`=4'b0001.
  - Stimulus: `ovf_clr`.
  - Required: `ovf`=0 while `pend[0]` stays 1.
- **Ack/event collision:**
  - Stimulus: `ev[2]` and `ack` with `ack_idx`=2 in the same cycle, with `pend[2]`=1.
  - Required: `pend[2]` remains 1 and `ovf[2]` remains 0.
- **Spurious ack and level hold:**
  - Stimulus: ack idx 1 while `pend`=4'b0100.
  - Required: `pend` unchanged.
  - Stimulus: `req_in[1]` held high for 20 cycles and acked once.
  - Required: `pend[1]` stays 0 after the ack.
- **Reset mid-operation:**
  - Stimulus: `pend`=4'b1111 and `ovf`=4'b0011, then `rst` for 1 cycle with `req_in`=0.
  - Required: all outputs 0 on the next cycle.
